// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter with a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_buf #(
  parameter int BAUD_RATE  = 19200,
  parameter int CLK_RATE   = 50_000_000,
  parameter int DIV_NUM    = CLK_RATE / BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       tx_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [FB-1:0]   shreg;
  logic [FB-1:0]   frame;
  logic [3:0]      bit_cnt;
  logic [11:0]     baud_cnt;
  logic [7:0]      head;
  logic            push;
  logic            pop;
  logic            bit_end;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = trmt & ~full;
  assign pop     = (state == LOAD);
  assign head    = mem[rd_ptr];
  assign bit_end = (baud_cnt == 12'(DIV_NUM - 1));
  // Idle and stop fill are ones, so bit 0 is the line level.
  assign TX      = shreg[0];

`ifdef UART_TX_PARITY_EN
  assign frame = {1'b1, ^head, head, 1'b0};
`else
  assign frame = {1'b1, head, 1'b0};
`endif

  // FIFO storage; a full FIFO drops the incoming byte.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame FSM: load head, shift bits, chain frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg    <= frame;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b1, shreg[FB-1:1]};
            if (bit_cnt == 4'(FB - 1)) begin
              tx_done <= 1'b1;
              if (!empty) begin
                state <= LOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf.
// Short bit period keeps the run small.
module tb_uart_tx_buf;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX;
  logic       busy;
  logic       full;
  logic       empty;
  logic       tx_done;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int base;
  int n;

  always #5 clk = ~clk;

  uart_tx_buf #(
    .DIV_NUM   (DIV),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .busy   (busy),
    .full   (full),
    .empty  (empty),
    .tx_done(tx_done)
  );

  always @(negedge clk)
    if (tx_done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Entered in the frame cycle 'start' (already sampled).
  task automatic tx_frame(input logic [7:0] b, input int start,
                          input int push_idx, input logic [7:0] pb);
    logic [10:0] f;
    int bad;
    int k;
    f = mk_frame(b);
    for (int i = 0; i < FB; i++) begin
      bad = 0;
      for (int j = 0; j < DIV; j++) begin
        k = i * DIV + j;
        if (k >= start) begin
          if (k > start) step();
          if (TX !== f[i]) bad++;
          if (tx_done !== 1'b0) bad++;
          if (k == push_idx) begin
            trmt = 1'b1;
            tx_data = pb;
          end else begin
            trmt = 1'b0;
          end
        end
      end
      if (i * DIV + DIV - 1 >= start)
        chk($sformatf("bit%0d_%02h", i, b), 16'(bad), 16'd0);
    end
  endtask

  task automatic wait_gap(output int highs);
    int cnt;
    cnt = 0;
    do begin
      step();
      trmt = 1'b0;
      cnt++;
    end while (TX === 1'b1 && cnt < 8 * DIV);
    highs = (TX === 1'b0) ? cnt - 1 : -1;
  endtask

  task automatic idle_check(input int cyc, input string tag);
    int bad;
    bad = 0;
    repeat (cyc) begin
      step();
      if (TX !== 1'b1) bad++;
    end
    chk(tag, 16'(bad), 16'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_done", tx_done, 0);
    rst = 1'b0;
    step();

    // single byte
    trmt = 1'b1;
    tx_data = 8'hA5;
    step();
    trmt = 1'b0;
    tx_data = 8'hFF;
    chk("c1_empty", empty, 0);
    chk("c1_busy", busy, 0);
    chk("c1_tx", TX, 1);
    step();
    chk("c2_busy", busy, 1);
    chk("c2_tx", TX, 1);
    chk("c2_empty", empty, 0);
    step();
    chk("c3_tx", TX, 0);
    chk("c3_empty", empty, 1);
    base = done_cnt;
    tx_frame(8'hA5, 0, -1, 8'h00);
    step();
    chk("a5_done", tx_done, 1);
    chk("a5_busy", busy, 0);
    step();
    chk("a5_done_end", tx_done, 0);
    chk("a5_pulses", 16'(done_cnt - base), 16'd1);
    idle_check(DIV, "a5_idle");

    // burst of six, last one dropped
    base = done_cnt;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) chk("b_start", TX, 0);
      chk($sformatf("b_full_c%0d", k), full, 16'(k == 5));
      trmt = 1'b1;
      tx_data = 8'(k + 1);
      step();
    end
    trmt = 1'b0;
    tx_frame(8'h01, 3, -1, 8'h00);
    for (int f = 2; f <= 5; f++) begin
      wait_gap(n);
      chk($sformatf("b_gap%0d", f), 16'(n), 16'd1);
      tx_frame(8'(f), 0, -1, 8'h00);
    end
    step();
    chk("b_done", tx_done, 1);
    chk("b_busy", busy, 0);
    step();
    chk("b_pulses", 16'(done_cnt - base), 16'd5);
    chk("b_empty", empty, 1);
    idle_check(3 * DIV, "b_no_sixth");

    // reset in data bit 3 of 0x3C, two queued
    trmt = 1'b1;
    tx_data = 8'h3C;
    step();
    tx_data = 8'h11;
    step();
    tx_data = 8'h22;
    step();
    trmt = 1'b0;
    chk("r_start", TX, 0);
    repeat (4 * DIV + 3) step();
    chk("r_bit3", TX, 1);
    chk("r_busy", busy, 1);
    chk("r_queued", empty, 0);
    base = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("r_tx", TX, 1);
    chk("r_busy0", busy, 0);
    chk("r_empty", empty, 1);
    chk("r_full", full, 0);
    chk("r_done", tx_done, 0);
    step();
    step();
    rst = 1'b0;
    idle_check(12 * DIV, "r_idle");
    chk("r_no_done", 16'(done_cnt - base), 16'd0);
    chk("r_still_empty", empty, 1);
    trmt = 1'b1;
    tx_data = 8'h55;
    step();
    trmt = 1'b0;
    step();
    step();
    tx_frame(8'h55, 0, -1, 8'h00);
    step();
    chk("r55_done", tx_done, 1);
    chk("r55_busy", busy, 0);
    idle_check(2 * DIV, "r55_idle");

    // push during the final stop bit
    base = done_cnt;
    trmt = 1'b1;
    tx_data = 8'h5A;
    step();
    trmt = 1'b0;
    step();
    step();
    tx_frame(8'h5A, 0, FB * DIV - 2, 8'hC3);
    wait_gap(n);
    chk("s_gap_load", 16'(n), 16'd1);
    tx_frame(8'hC3, 0, FB * DIV - 1, 8'h96);
    wait_gap(n);
    chk("s_gap_idle", 16'(n), 16'd2);
    tx_frame(8'h96, 0, -1, 8'h00);
    step();
    chk("s_done", tx_done, 1);
    chk("s_busy", busy, 0);
    idle_check(3 * DIV, "s_once");
    chk("s_pulses", 16'(done_cnt - base), 16'd3);
    chk("s_empty", empty, 1);

`ifdef UART_TX_PARITY_EN
    trmt = 1'b1;
    tx_data = 8'h07;
    step();
    trmt = 1'b0;
    step();
    step();
    tx_frame(8'h07, 0, -1, 8'h00);
    step();
    chk("p07_done", tx_done, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter: the transmit-side counterpart of the Segway UART receiver, sharing its baud configuration and frame format (8N1, LSB first). Bytes written through a simple strobe interface are queued in a small FIFO and serialized back-to-back on `TX`. It sits between the command/telemetry logic and the serial pin, letting a producer burst several bytes without waiting for each frame.

## Interface
- `BAUD_RATE`, default 19200: serial bit rate.
- `CLK_RATE`, default 50_000_000: `clk` frequency in Hz.
- `DIV_NUM`, default CLK_RATE/BAUD_RATE (2604): clocks per bit.
- `FIFO_DEPTH`, default 4: byte entries; power of two, at least 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `trmt`  in  1  write strobe; pushes `tx_data` when `full` is 0.
- `tx_data`  in  8  byte to queue.
- `TX`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is loading or shifting.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `tx_done`  out  1  one-cycle pulse per completed frame.

## Operation
- FIFO: circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1. `full` and `empty` are decoded from the registered count.
- Push: when `trmt`=1 and `full`=0, `tx_data` is written at the cycle's closing edge. When `trmt`=1 and `full`=1, the byte is silently dropped and FIFO state is unchanged, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: `TX`=1. Moves to LOAD when `empty`=0.
  - LOAD: pops the head into a shift register as {stop=1, data[7:0], start=0}, clears the bit and baud counters, and moves to SHIFT.
  - SHIFT: drives shift-register bit 0 on `TX`. The baud counter counts DIV_NUM cycles per bit, then the register shifts right. After the stop bit completes, the FSM goes to LOAD if `empty`=0, else to IDLE.
- Bit counter counts 0..9 (0..10 with parity). Baud counter is 12 bits wide and must hold DIV_NUM-1.
- `busy`=1 in LOAD and SHIFT.
- `tx_done` pulses for one cycle, in the cycle right after the last stop-bit cycle.

## Timing
- Reset values: `TX`=1, `busy`=0, `full`=0, `empty`=1, `tx_done`=0, FSM=IDLE, pointers and count=0.
- Reset mid-frame forces `TX` high immediately, discards the FIFO contents and the frame in flight, and produces no `tx_done`.
- Latency from an idle, empty state, with `trmt` high in cycle 0:
  - cycle 1: IDLE, `empty`=0.
  - cycle 2: LOAD, pop at the closing edge.
  - cycle 3: SHIFT, `TX`=0.
- Every bit, start and stop included, lasts exactly DIV_NUM cycles. A frame is 10×DIV_NUM cycles.
- Back-to-back frames have exactly one extra `TX`-high cycle (LOAD) after the stop bit.
- `tx_data` only needs to be valid in the cycle `trmt` is high. Changing it during a frame does not affect the byte in flight.

## Configuration
- `UART_TX_PARITY_EN` defined: an even-parity bit (XOR of data[7:0]) is inserted between data bit 7 and the stop bit. The frame is 11 bits, 11×DIV_NUM cycles.
- `UART_TX_PARITY_EN` undefined: 8N1, 10-bit frame, no parity logic.

## Test plan
- Single byte 0xA5 from idle → `TX` falls 3 cycles after `trmt`, then emits 0,1,0,1,0,0,1,0,1,1, each bit held 2604 cycles. `tx_done` pulses once and `busy` falls in the same cycle.
- Burst of 6 bytes 0x01..0x06 on consecutive cycles from idle → `full` rises in cycle 5, 0x06 is dropped, 0x01..0x05 are sent in order. There are exactly 2605 `TX`-high cycles between each pair of frames, and 5 `tx_done` pulses in total.
- Assert `rst` in the middle of data bit 3 of 0x3C with 2 bytes queued → `TX`=1 immediately, `empty`=1, no `tx_done`. A new 0x55 afterwards transmits correctly.
- With `UART_TX_PARITY_EN`: 0xA5 gives parity bit 0 and 0x07 gives parity bit 1. Both frames are 11 bits and 28644 cycles.
- Push while the last stop bit is in progress and the FIFO is empty → the FSM goes to LOAD rather than IDLE if the byte lands before the stop bit ends. In either case the byte is sent exactly once.
